// File: rtl/reg_select_sequencer_if.sv
// ---------------------------------------------------------------------------
// reg_select_sequencer_if
//   Host-side bundle for the register-select sequencer: the address/strobe
//   inputs coming from the host pins and the select/status outputs going to
//   the CTRL/DATA register bank.
//
//   Parameters
//     ADDR_W  width of the register address
//     NSEL    width of the one-hot select bus (N_CTRL + N_DATA of the sequencer)
//
//   Signals
//     adr_in, adr_load, burst_req, access, enable_output   host -> sequencer
//     sel, sel_valid, addr_err, cur_addr, burst_done       sequencer -> host/bank
//
//   Modports
//     master  the host side (drives the strobes, observes the status)
//     slave   the sequencer itself
// ---------------------------------------------------------------------------
interface reg_select_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int NSEL   = 11
);

  logic [ADDR_W-1:0] adr_in;
  logic              adr_load;
  logic              burst_req;
  logic              access;
  logic              enable_output;

  logic [NSEL-1:0]   sel;
  logic              sel_valid;
  logic              addr_err;
  logic [ADDR_W-1:0] cur_addr;
  logic              burst_done;

  modport master (
    output adr_in, adr_load, burst_req, access, enable_output,
    input  sel, sel_valid, addr_err, cur_addr, burst_done
  );

  modport slave (
    input  adr_in, adr_load, burst_req, access, enable_output,
    output sel, sel_valid, addr_err, cur_addr, burst_done
  );

endinterface

// File: rtl/reg_select_sequencer.sv
// ---------------------------------------------------------------------------
// reg_select_sequencer
//   Latches a register address from the host and drives a one-hot select into
//   the CTRL/DATA register bank. In burst mode every completed access advances
//   the address through the CTRL window, jumps the hole to the DATA window and
//   stops after the last DATA register with a one-cycle burst_done pulse.
//
//   Address map (index on the select bus):
//     0 .. N_CTRL-1                      -> 0 .. N_CTRL-1
//     DATA_BASE .. DATA_BASE+N_DATA-1    -> N_CTRL .. N_CTRL+N_DATA-1
//     anything else                      -> unmapped (addr_err)
//
//   Ports
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    reg_select_sequencer_if.slave:
//              in : adr_in, adr_load, burst_req, access, enable_output
//              out: sel, sel_valid, addr_err, cur_addr, burst_done
//
//   The interface instance must be parameterised with the same ADDR_W and
//   with NSEL = N_CTRL + N_DATA.
// ---------------------------------------------------------------------------
module reg_select_sequencer #(
  parameter int ADDR_W    = 4,
  parameter int N_CTRL    = 3,
  parameter int DATA_BASE = 8,
  parameter int N_DATA    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  reg_select_sequencer_if.slave         bus
);

  localparam int NSEL  = N_CTRL + N_DATA;
  localparam int IDX_W = (NSEL > 1) ? $clog2(NSEL) : 1;

  // Window boundaries in address width so all comparisons stay ADDR_W bits.
  localparam logic [ADDR_W-1:0] CTRL_LAST  = ADDR_W'(N_CTRL - 1);
  localparam logic [ADDR_W-1:0] DATA_FIRST = ADDR_W'(DATA_BASE);
  localparam logic [ADDR_W-1:0] DATA_LAST  = ADDR_W'(DATA_BASE + N_DATA - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SINGLE = 2'd1,
    S_BURST  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              sel_valid_q, sel_valid_d;
  logic              addr_err_q, addr_err_d;
  logic              burst_done_q, burst_done_d;

  logic [IDX_W-1:0]  cur_idx;
  logic [NSEL-1:0]   sel_vec;

  function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
    return (a <= CTRL_LAST) || ((a >= DATA_FIRST) && (a <= DATA_LAST));
  endfunction

  // Only meaningful for mapped addresses; the caller gates with sel_valid.
  function automatic logic [IDX_W-1:0] map_index(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] offs;
    offs = a - DATA_FIRST;
    if (a <= CTRL_LAST) begin
      return IDX_W'(a);
    end
    return IDX_W'(N_CTRL) + IDX_W'(offs);
  endfunction

  // Next-state logic. A load has priority over an access in the same cycle,
  // so a simultaneous access is simply dropped. sel_valid/addr_err are
  // derived from the next state so that they are registered alongside it.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    burst_done_d = 1'b0;

    if (bus.adr_load) begin
      cur_addr_d = bus.adr_in;
      state_d    = bus.burst_req ? S_BURST : S_SINGLE;
    end else if ((state_q == S_BURST) && bus.access) begin
      if (!is_mapped(cur_addr_q)) begin
        // Error abort: leave quietly, no completion pulse.
        state_d = S_IDLE;
      end else if (cur_addr_q == DATA_LAST) begin
        state_d      = S_IDLE;
        burst_done_d = 1'b1;
      end else if (cur_addr_q == CTRL_LAST) begin
        // Skip the unmapped hole between the CTRL and DATA windows.
        cur_addr_d = DATA_FIRST;
      end else begin
        cur_addr_d = cur_addr_q + ADDR_W'(1);
      end
    end

    sel_valid_d = (state_d != S_IDLE) &&  is_mapped(cur_addr_d);
    addr_err_d  = (state_d != S_IDLE) && !is_mapped(cur_addr_d);
  end

  // State and registered status flags, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      sel_valid_q  <= 1'b0;
      addr_err_q   <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      sel_valid_q  <= sel_valid_d;
      addr_err_q   <= addr_err_d;
      burst_done_q <= burst_done_d;
    end
  end

  // One-hot decode of the current address; enable_output only masks the
  // bus, it never feeds back into the state.
  always_comb begin
    cur_idx = map_index(cur_addr_q);
    sel_vec = '0;
    if (bus.enable_output && sel_valid_q) begin
      for (int i = 0; i < NSEL; i++) begin
        sel_vec[i] = (cur_idx == IDX_W'(i));
      end
    end
  end

  assign bus.sel        = sel_vec;
  assign bus.sel_valid  = sel_valid_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.cur_addr   = cur_addr_q;
  assign bus.burst_done = burst_done_q;

endmodule
